digit_display_ctrl: RTL

Pixel-stream controller that sequences the per-digit glyph ROM bank (8x16 glyphs, 6-bit RRGGBB colour, 5-bit col/row addressing) to draw a multi-digit height readout in a fixed screen window. It sits between the video timing generator and the colour output stage. Each pixel, it maps the beam coordinate to a digit slot, glyph column and glyph row, drives the ROM bank, and registers the returned colour. Displayed values change only at frame boundaries, so the readout never tears.

---
 rtl/display_pkg.sv | 24 ++
 rtl/digit_region_map.sv | 52 +++++
 rtl/digit_display_ctrl.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/display_pkg.sv
// Shared types and constants for the digit readout: glyph geometry, colour
// codes and the value-update state encoding.
package display_pkg;

  localparam int GLYPH_W = 8;
  localparam int GLYPH_H = 16;

  typedef logic [5:0] rgb_t;
  typedef logic [3:0] bcd_t;

  localparam rgb_t COLOR_BG    = 6'b111111;
  localparam rgb_t COLOR_BLANK = 6'b000000;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } upd_state_t;

  // Codes above 9 have no glyph and render as background
  function automatic logic is_digit(input bcd_t code);
    return (code <= 4'd9);
  endfunction

endpackage

// File: rtl/digit_region_map.sv
// Combinational map from beam coordinate to {in_win, slot, glyph col, glyph row}
// for a window of NUM_DIGITS glyph cells magnified by 2^SCALE_LOG2.
module digit_region_map
  import display_pkg::*;
#(
  parameter int NUM_DIGITS = 3,
  parameter int X0         = 256,
  parameter int Y0         = 224,
  parameter int SCALE_LOG2 = 2,
  parameter int SLOT_W     = 2
) (
  input  logic [9:0]        hcount,
  input  logic [9:0]        vcount,
  output logic              in_win,
  output logic [SLOT_W-1:0] slot,
  output logic [2:0]        col,
  output logic [3:0]        row
);

  localparam int GW_LOG2 = $clog2(GLYPH_W);
  localparam int GH_LOG2 = $clog2(GLYPH_H);

  logic [9:0] dx;
  logic [9:0] dy;
  logic [9:0] sx;
  logic [9:0] sy;
  logic [9:0] slot_full;
  logic       in_x;
  logic       in_y;

  // Window bounds are tested on the scaled offsets, so the full offset width feeds the decision
  always_comb begin
    dx        = hcount - 10'(X0);
    dy        = vcount - 10'(Y0);
    sx        = dx >> SCALE_LOG2;
    sy        = dy >> SCALE_LOG2;
    slot_full = sx >> GW_LOG2;
    in_x      = (hcount >= 10'(X0)) && (slot_full < 10'(NUM_DIGITS));
    in_y      = (vcount >= 10'(Y0)) && ((sy >> GH_LOG2) == 10'd0);
    in_win    = in_x && in_y;
    if (in_win) begin
      slot = slot_full[SLOT_W-1:0];
      col  = sx[2:0];
      row  = sy[3:0];
    end else begin
      slot = '0;
      col  = 3'd0;
      row  = 4'd0;
    end
  end

endmodule

// File: rtl/digit_display_ctrl.sv
// Two-stage pixel pipeline drawing a NUM_DIGITS BCD readout from an external glyph ROM bank.
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module digit_display_ctrl
  import display_pkg::*;
#(
  parameter int NUM_DIGITS = 3,
  parameter int X0         = 256,
  parameter int Y0         = 224,
  parameter int SCALE_LOG2 = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [9:0]              hcount,
  input  logic [9:0]              vcount,
  input  logic                    pix_valid,
  input  logic                    frame_start,
  input  logic [4*NUM_DIGITS-1:0] value_bcd,
  input  logic                    value_valid,
  output logic [3:0]              glyph_sel,
  output logic [4:0]              glyph_col,
  output logic [4:0]              glyph_row,
  input  logic [5:0]              glyph_data,
  output logic [5:0]              rgb,
  output logic                    rgb_valid
);

  localparam int SLOT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int VAL_W  = 4 * NUM_DIGITS;

  upd_state_t            state;
  logic [VAL_W-1:0]      pending_val;
  logic [VAL_W-1:0]      shown_val;
  logic [NUM_DIGITS-1:0] blank_mask;
  logic [NUM_DIGITS-1:0] next_blank;

  logic              map_in_win;
  logic [SLOT_W-1:0] map_slot;
  logic [2:0]        map_col;
  logic [3:0]        map_row;
  bcd_t              cur_code;
  logic              cur_blank;

  logic              s1_in_win;
  logic              s1_valid;
  logic              s1_blank;

  digit_region_map #(
    .NUM_DIGITS (NUM_DIGITS),
    .X0         (X0),
    .Y0         (Y0),
    .SCALE_LOG2 (SCALE_LOG2),
    .SLOT_W     (SLOT_W)
  ) u_map (
    .hcount (hcount),
    .vcount (vcount),
    .in_win (map_in_win),
    .slot   (map_slot),
    .col    (map_col),
    .row    (map_row)
  );

`ifdef LEADING_ZERO_BLANK_EN
  logic all_zero;

  // Blank a slot while every more significant slot is zero; the last slot always draws
  always_comb begin
    all_zero   = 1'b1;
    next_blank = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      all_zero = all_zero & (pending_val[VAL_W-1-4*i -: 4] == 4'd0);
      if (i < NUM_DIGITS - 1) begin
        next_blank[i] = all_zero;
      end else begin
        next_blank[i] = 1'b0;
      end
    end
  end
`else
  // Without leading-zero blanking every slot renders its digit
  always_comb begin
    next_blank = '0;
  end
`endif

  // Update FSM: values are staged in pending_val and only swapped in on frame_start
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      pending_val <= '0;
      shown_val   <= '0;
      blank_mask  <= '0;
    end else begin
      if (value_valid) begin
        pending_val <= value_bcd;
      end
      case (state)
        ST_IDLE: begin
          if (value_valid) begin
            state <= ST_PENDING;
          end
        end
        ST_PENDING: begin
          if (frame_start) begin
            shown_val  <= pending_val;
            blank_mask <= next_blank;
            if (!value_valid) begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Pick the shown digit and blank flag for the slot under the beam
  always_comb begin
    cur_code  = 4'h0;
    cur_blank = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (map_slot == SLOT_W'(i)) begin
        cur_code  = shown_val[VAL_W-1-4*i -: 4];
        cur_blank = blank_mask[i];
      end else begin
        cur_code  = cur_code;
        cur_blank = cur_blank;
      end
    end
  end

  // Stage 1: present ROM address and carry window/valid/blank alongside it
  always_ff @(posedge clk) begin
    if (reset) begin
      glyph_sel <= 4'd0;
      glyph_col <= 5'd0;
      glyph_row <= 5'd0;
      s1_in_win <= 1'b0;
      s1_valid  <= 1'b0;
      s1_blank  <= 1'b0;
    end else begin
      glyph_sel <= map_in_win ? cur_code : 4'd0;
      glyph_col <= {2'b00, map_col};
      glyph_row <= {1'b0, map_row};
      s1_in_win <= map_in_win;
      s1_valid  <= pix_valid;
      s1_blank  <= map_in_win & cur_blank;
    end
  end

  // Stage 2: choose between blanking, background and the ROM colour
  always_ff @(posedge clk) begin
    if (reset) begin
      rgb       <= COLOR_BLANK;
      rgb_valid <= 1'b0;
    end else begin
      rgb_valid <= s1_valid;
      if (!s1_valid) begin
        rgb <= COLOR_BLANK;
      end else if (!s1_in_win || s1_blank || !is_digit(glyph_sel)) begin
        rgb <= COLOR_BG;
      end else begin
        rgb <= glyph_data;
      end
    end
  end

endmodule
